afe_spi_responder: RTL and testbench

SPI responder (peripheral) modelling the AFE4490 register interface: it receives 32-bit frames (8-bit address followed by 24-bit data, MSB first, mode 0) from the team's SPI initiator and either writes a 24-bit register or shifts one out on MISO. The register file is shared with a local read port. The block serves as a loop-back partner for initiator verification and as the device-side front end in FPGA-emulated AFE setups. All SPI inputs are oversampled on the system clock; there is no logic clocked by SCLK.

---
 rtl/afe_spi_responder.sv | 220 ++++++++++++++++++++++
 tb/tb_afe_spi_responder.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/afe_spi_responder.sv
// afe_spi_responder: SPI mode-0 responder with a 24-bit register file.
// SCLK, CS_N and MOSI are oversampled on i_clk. Frames are 8-bit address + 24-bit data.
//
// state      | meaning
// -----------+------------------------------------------------------------
// ST_IDLE    | CS high or frame not yet started; counters cleared
// ST_ADDR    | shifting in the 8 address bits
// ST_DATA    | shifting 24 data bits in (write) or out on MISO (read)
// ST_WAIT_CS | frame complete; SCLK ignored until CS rises
module afe_spi_responder #(
   parameter int NUM_REGS = 16
) (
   input  logic        i_clk,
   input  logic        i_rst,
   input  logic        i_sclk,
   input  logic        i_cs_n,
   input  logic        i_mosi,
   output logic        o_miso,
   output logic        o_miso_oe,
   output logic        o_wr_pulse,
   output logic [7:0]  o_wr_addr,
   output logic [23:0] o_wr_data,
   output logic        o_spi_read,
   output logic        o_frame_err,
   input  logic [7:0]  i_lcl_addr,
   output logic [23:0] o_lcl_data
);

   localparam int AW = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;

   typedef enum logic [1:0] {ST_IDLE, ST_ADDR, ST_DATA, ST_WAIT_CS} state_t;

   state_t      state_q, state_d;

   logic        sclk_s1_q, sclk_s2_q, sclk_h_q;
   logic        cs_s1_q, cs_s2_q, cs_h_q;
   logic        mosi_s1_q, mosi_s2_q, mosi_h_q;
   logic        sclk_rise_q, sclk_fall_q, cs_rise_q, cs_fall_q;
   logic        vld1_q, vld2_q, armed_q;

   logic [5:0]  cnt_q;
   logic [22:0] sh_q;
   logic [23:0] tx_q;
   logic        oe_q;
   logic        rd_q;
   logic [7:0]  addr_q;
   logic [23:0] regs_q [NUM_REGS];
   logic        wr_pulse_q, frame_err_q;
   logic [7:0]  wr_addr_q;
   logic [23:0] wr_data_q;
   logic [23:0] lcl_data_q;

   logic        shift_rx, latch_addr, load_tx, shift_tx, do_wr, frame_err;
   logic [7:0]  addr_nxt;
   logic        rd_nxt;
   logic [23:0] wdata;

   function automatic logic in_range(input logic [7:0] a);
      return {24'd0, a} < 32'(NUM_REGS);
   endfunction

   assign addr_nxt = {sh_q[6:0], mosi_h_q};
   assign rd_nxt   = (addr_nxt != 8'h00) && regs_q[0][0];
   assign wdata    = {sh_q, mosi_h_q};

   // Synchronize SPI pins and register edge strobes. A CS fall is only honoured once CS
   // has been seen high after reset, so a frame cut by reset is ignored until CS cycles.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         sclk_s1_q   <= 1'b0;
         sclk_s2_q   <= 1'b0;
         sclk_h_q    <= 1'b0;
         cs_s1_q     <= 1'b1;
         cs_s2_q     <= 1'b1;
         cs_h_q      <= 1'b1;
         mosi_s1_q   <= 1'b0;
         mosi_s2_q   <= 1'b0;
         mosi_h_q    <= 1'b0;
         sclk_rise_q <= 1'b0;
         sclk_fall_q <= 1'b0;
         cs_rise_q   <= 1'b0;
         cs_fall_q   <= 1'b0;
         vld1_q      <= 1'b0;
         vld2_q      <= 1'b0;
         armed_q     <= 1'b0;
      end else begin
         sclk_s1_q   <= i_sclk;
         sclk_s2_q   <= sclk_s1_q;
         sclk_h_q    <= sclk_s2_q;
         cs_s1_q     <= i_cs_n;
         cs_s2_q     <= cs_s1_q;
         cs_h_q      <= cs_s2_q;
         mosi_s1_q   <= i_mosi;
         mosi_s2_q   <= mosi_s1_q;
         mosi_h_q    <= mosi_s2_q;
         sclk_rise_q <= sclk_s2_q & ~sclk_h_q;
         sclk_fall_q <= ~sclk_s2_q & sclk_h_q;
         cs_rise_q   <= cs_s2_q & ~cs_h_q;
         cs_fall_q   <= armed_q & ~cs_s2_q & cs_h_q;
         vld1_q      <= 1'b1;
         vld2_q      <= vld1_q;
         armed_q     <= armed_q | (vld2_q & cs_s2_q);
      end
   end

   // FSM state register
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) state_q <= ST_IDLE;
      else       state_q <= state_d;
   end

   // Next-state and per-cycle datapath commands
   always_comb begin
      state_d    = state_q;
      shift_rx   = 1'b0;
      latch_addr = 1'b0;
      load_tx    = 1'b0;
      shift_tx   = 1'b0;
      do_wr      = 1'b0;
      frame_err  = 1'b0;
      unique case (state_q)
         ST_IDLE: begin
            if (cs_fall_q) state_d = ST_ADDR;
         end
         ST_ADDR: begin
            if (cs_rise_q) begin
               frame_err = 1'b1;
               state_d   = ST_IDLE;
            end else if (sclk_rise_q) begin
               shift_rx = 1'b1;
               if (cnt_q == 6'd7) begin
                  latch_addr = 1'b1;
                  state_d    = ST_DATA;
               end
            end
         end
         ST_DATA: begin
            if (cs_rise_q) begin
               frame_err = 1'b1;
               state_d   = ST_IDLE;
            end else begin
               if (sclk_rise_q) begin
                  shift_rx = 1'b1;
                  if (cnt_q == 6'd31) begin
                     do_wr   = !rd_q && in_range(addr_q);
                     state_d = ST_WAIT_CS;
                  end
               end
               if (sclk_fall_q && rd_q) begin
                  load_tx  = !oe_q;
                  shift_tx = oe_q;
               end
            end
         end
         ST_WAIT_CS: begin
            if (cs_rise_q) state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // Shift registers, register file, write/abort strobes and local read port
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         cnt_q       <= '0;
         sh_q        <= '0;
         tx_q        <= '0;
         oe_q        <= 1'b0;
         rd_q        <= 1'b0;
         addr_q      <= '0;
         wr_pulse_q  <= 1'b0;
         frame_err_q <= 1'b0;
         wr_addr_q   <= '0;
         wr_data_q   <= '0;
         lcl_data_q  <= '0;
         for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
      end else begin
         wr_pulse_q  <= do_wr;
         frame_err_q <= frame_err;
         lcl_data_q  <= in_range(i_lcl_addr) ? regs_q[i_lcl_addr[AW-1:0]] : '0;
         if (state_d == ST_IDLE) begin
            cnt_q <= '0;
            sh_q  <= '0;
            tx_q  <= '0;
            oe_q  <= 1'b0;
            rd_q  <= 1'b0;
         end else begin
            if (shift_rx) begin
               sh_q  <= {sh_q[21:0], mosi_h_q};
               cnt_q <= cnt_q + 6'd1;
            end
            if (latch_addr) begin
               addr_q <= addr_nxt;
               rd_q   <= rd_nxt;
            end
            if (load_tx) begin
               tx_q <= in_range(addr_q) ? regs_q[addr_q[AW-1:0]] : '0;
               oe_q <= 1'b1;
            end else if (shift_tx) begin
               tx_q <= {tx_q[22:0], 1'b0};
            end
         end
         if (do_wr) begin
            regs_q[addr_q[AW-1:0]] <= wdata;
            wr_addr_q              <= addr_q;
            wr_data_q              <= wdata;
         end
      end
   end

   assign o_miso      = oe_q & tx_q[23];
   assign o_miso_oe   = oe_q;
   assign o_wr_pulse  = wr_pulse_q;
   assign o_wr_addr   = wr_addr_q;
   assign o_wr_data   = wr_data_q;
   assign o_spi_read  = regs_q[0][0];
   assign o_frame_err = frame_err_q;
   assign o_lcl_data  = lcl_data_q;

endmodule

// File: tb/tb_afe_spi_responder.sv
// Testbench for afe_spi_responder: directed SPI frames, scoreboard of expected strobes
// and MISO words, with monitors comparing as the DUT presents them.
module tb_afe_spi_responder;

   logic        clk = 1'b0;
   logic        rst;
   logic        sclk = 1'b0;
   logic        cs_n = 1'b1;
   logic        mosi = 1'b0;
   logic [7:0]  lcl_addr = 8'h00;
   logic        miso, miso_oe, wr_pulse, spi_read, frame_err_o;
   logic [7:0]  wr_addr;
   logic [23:0] wr_data, lcl_data;

   afe_spi_responder #(.NUM_REGS(16)) dut (
      .i_clk      (clk),
      .i_rst      (rst),
      .i_sclk     (sclk),
      .i_cs_n     (cs_n),
      .i_mosi     (mosi),
      .o_miso     (miso),
      .o_miso_oe  (miso_oe),
      .o_wr_pulse (wr_pulse),
      .o_wr_addr  (wr_addr),
      .o_wr_data  (wr_data),
      .o_spi_read (spi_read),
      .o_frame_err(frame_err_o),
      .i_lcl_addr (lcl_addr),
      .o_lcl_data (lcl_data)
   );

   always #5 clk = ~clk;

   typedef struct {
      bit          is_err;
      logic [7:0]  a;
      logic [23:0] d;
   } ev_t;

   ev_t         exp_q[$];
   logic [23:0] rd_exp_q[$];
   int          checks = 0;
   int          errors = 0;
   bit          rd_frame = 1'b0;
   int          rise_cnt = 0;
   int          nb = 0;
   logic [23:0] bits = '0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h required=%h", name, act, exp);
      end
   endtask

   task automatic push_wr(input logic [7:0] a, input logic [23:0] d);
      ev_t e;
      e.is_err = 1'b0;
      e.a      = a;
      e.d      = d;
      exp_q.push_back(e);
   endtask

   task automatic push_err();
      ev_t e;
      e.is_err = 1'b1;
      e.a      = '0;
      e.d      = '0;
      exp_q.push_back(e);
   endtask

   // Strobe monitor: every write or abort strobe must match the head of the scoreboard
   always @(negedge clk) begin : strobe_mon
      ev_t e;
      if (rst === 1'b0) begin
         if (wr_pulse) begin
            if (exp_q.size() == 0) chk("unexpected_wr_pulse", 32'd1, 32'd0);
            else begin
               e = exp_q.pop_front();
               chk("wr_kind", 32'(e.is_err), 32'd0);
               chk("wr_addr", 32'(wr_addr), 32'(e.a));
               chk("wr_data", 32'(wr_data), 32'(e.d));
            end
         end
         if (frame_err_o) begin
            if (exp_q.size() == 0) chk("unexpected_frame_err", 32'd1, 32'd0);
            else begin
               e = exp_q.pop_front();
               chk("err_kind", 32'(e.is_err), 32'd1);
            end
         end
      end
   end

   always @(negedge cs_n) begin
      rise_cnt = 0;
      nb       = 0;
   end

   // MISO monitor: output enable per SCLK rise, and assembled read words vs scoreboard
   always @(posedge sclk) begin : miso_mon
      logic [23:0] e;
      if (rst === 1'b0) begin
         chk("miso_oe", 32'(miso_oe), 32'(rd_frame && rise_cnt >= 8));
         if (rd_frame && rise_cnt >= 8 && rise_cnt < 32) begin
            bits = {bits[22:0], miso};
            nb++;
            if (nb == 24) begin
               if (rd_exp_q.size() == 0) chk("unexpected_read_word", 32'd1, 32'd0);
               else begin
                  e = rd_exp_q.pop_front();
                  chk("miso_word", 32'(bits), 32'(e));
               end
            end
         end
         rise_cnt++;
      end
   end

   task automatic chk_reset_outputs(input string tag);
      chk({tag, "_miso"},      32'(miso),        32'd0);
      chk({tag, "_miso_oe"},   32'(miso_oe),     32'd0);
      chk({tag, "_wr_pulse"},  32'(wr_pulse),    32'd0);
      chk({tag, "_wr_addr"},   32'(wr_addr),     32'd0);
      chk({tag, "_wr_data"},   32'(wr_data),     32'd0);
      chk({tag, "_spi_read"},  32'(spi_read),    32'd0);
      chk({tag, "_frame_err"}, 32'(frame_err_o), 32'd0);
      chk({tag, "_lcl_data"},  32'(lcl_data),    32'd0);
   endtask

   // One SPI frame of nbits clocks; bits beyond 32 are ones. rst_at >= 0 pulses reset
   // before that bit, with SCLK low and CS still asserted.
   task automatic frame(input logic [7:0] a, input logic [23:0] d, input int nbits,
                        input int rst_at);
      logic [31:0] w;
      w = {a, d};
      @(negedge clk);
      cs_n = 1'b0;
      repeat (4) @(negedge clk);
      for (int i = 0; i < nbits; i++) begin
         if (i == rst_at) begin
            rst = 1'b1;
            @(negedge clk);
            chk_reset_outputs("midrst");
            repeat (2) @(negedge clk);
            rst = 1'b0;
         end
         mosi = (i < 32) ? w[31-i] : 1'b1;
         repeat (4) @(negedge clk);
         sclk = 1'b1;
         repeat (4) @(negedge clk);
         sclk = 1'b0;
      end
      repeat (4) @(negedge clk);
      cs_n = 1'b1;
      mosi = 1'b0;
      repeat (10) @(negedge clk);
   endtask

   task automatic lcl(input logic [7:0] a, input logic [23:0] e, input string name);
      @(negedge clk);
      lcl_addr = a;
      @(negedge clk);
      chk(name, 32'(lcl_data), 32'(e));
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1);
   end

   initial begin
      rst = 1'b0;
      #2 rst = 1'b1;
      repeat (3) @(negedge clk);
      chk_reset_outputs("reset");
      rst = 1'b0;
      repeat (5) @(negedge clk);

      // basic write and local readback
      push_wr(8'h05, 24'hA50F55);
      frame(8'h05, 24'hA50F55, 32, -1);
      lcl(8'h05, 24'hA50F55, "lcl_reg5");
      chk("wr_addr_held", 32'(wr_addr), 32'h05);
      chk("wr_data_held", 32'(wr_data), 32'hA50F55);

      // abort: reg 3 keeps its previous value
      push_wr(8'h03, 24'h111111);
      frame(8'h03, 24'h111111, 32, -1);
      push_err();
      frame(8'h03, 24'hFFFFFF, 20, -1);
      lcl(8'h03, 24'h111111, "lcl_reg3_after_abort");

      // last implemented register, then out-of-range writes dropped
      push_wr(8'h0F, 24'h0F0F0F);
      frame(8'h0F, 24'h0F0F0F, 32, -1);
      lcl(8'h0F, 24'h0F0F0F, "lcl_reg15");
      frame(8'h10, 24'hABCDEF, 32, -1);
      frame(8'h20, 24'h5A5A5A, 32, -1);
      lcl(8'h10, 24'h000000, "lcl_oor_16");
      lcl(8'h20, 24'h000000, "lcl_oor_32");
      lcl(8'h00, 24'h000000, "lcl_reg0_unchanged");

      // enter read mode and read back
      push_wr(8'h00, 24'h000001);
      frame(8'h00, 24'h000001, 32, -1);
      chk("spi_read_set", 32'(spi_read), 32'd1);
      rd_frame = 1'b1;
      rd_exp_q.push_back(24'hA50F55);
      frame(8'h05, 24'h000000, 32, -1);
      rd_exp_q.push_back(24'h000000);
      frame(8'h20, 24'h000000, 32, -1);
      rd_exp_q.push_back(24'h111111);
      frame(8'h03, 24'hFFFFFF, 32, -1);
      rd_frame = 1'b0;
      chk("miso_oe_after_cs", 32'(miso_oe), 32'd0);
      lcl(8'h05, 24'hA50F55, "lcl_reg5_after_read");

      // address 0 is always a write, leaving read mode
      push_wr(8'h00, 24'h000000);
      frame(8'h00, 24'h000000, 32, -1);
      chk("spi_read_clr", 32'(spi_read), 32'd0);

      // overlong frame: commit on 32nd rise, extra bits ignored
      push_wr(8'h02, 24'h123456);
      frame(8'h02, 24'h123456, 40, -1);
      lcl(8'h02, 24'h123456, "lcl_reg2_overlong");

      // reset during the data phase of a write to 7
      frame(8'h07, 24'h777777, 32, 20);
      lcl(8'h07, 24'h000000, "lcl_reg7_after_rst");
      lcl(8'h05, 24'h000000, "lcl_reg5_after_rst");
      chk("wr_addr_after_rst", 32'(wr_addr), 32'd0);
      push_wr(8'h07, 24'h0F0F0F);
      frame(8'h07, 24'h0F0F0F, 32, -1);
      lcl(8'h07, 24'h0F0F0F, "lcl_reg7_post_rst");

      repeat (10) @(negedge clk);
      chk("scoreboard_strobes_left", 32'(exp_q.size()), 32'd0);
      chk("scoreboard_reads_left", 32'(rd_exp_q.size()), 32'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
